// File: rtl/uart_boot_ctrl.sv
// UART bootloader: parses sync/length/payload/checksum frames into imem writes
// and keeps the cores in reset until a frame ends with a matching checksum.
module uart_boot_ctrl #(
    parameter int         ADDR_WIDTH     = 8,
    parameter int         DATA_WIDTH     = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_data,
    output logic                  imem_we,
    output logic                  cpu_hold,
    output logic                  boot_done,
    output logic [1:0]            boot_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int WW = ADDR_WIDTH + 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [16:0]   MAX_LEN  = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_L,
        S_LEN_H,
        S_DATA_L,
        S_DATA_H,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_len;
    logic [7:0]            r_lo;
    logic [7:0]            r_csum;
    logic [TW-1:0]         r_tmo;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_we;
    logic                  r_hold;
    logic                  r_done;
    logic [1:0]            r_err;
    logic [WW-1:0]         r_words;

    logic                  w_in_frame;
    logic                  w_expire;
    logic                  w_sync;
    logic [15:0]           w_len;
    logic                  w_ovf;
    logic                  w_last;
    logic                  w_csum_ok;
    logic [7:0]            w_csum_add;

    assign w_len      = {rx_byte, r_len[7:0]};
    assign w_ovf      = {1'b0, w_len} > MAX_LEN;
    assign w_last     = (17'(r_words) + 17'd1) == {1'b0, r_len};
    assign w_csum_add = r_csum + rx_byte;
    assign w_csum_ok  = rx_byte == r_csum;
    assign w_sync     = rx_valid && (rx_byte == SYNC_BYTE);
    assign w_in_frame = (r_state == S_LEN_L) || (r_state == S_LEN_H) ||
                        (r_state == S_DATA_L) || (r_state == S_DATA_H) ||
                        (r_state == S_CSUM);
    // An arriving byte always beats an expiring counter
    assign w_expire   = w_in_frame && !rx_valid && (r_tmo == TMO_LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: if (w_sync) w_next = S_LEN_L;
            S_LEN_L:  if (rx_valid) w_next = S_LEN_H;
            S_LEN_H: begin
                if (rx_valid) begin
                    if (w_ovf)            w_next = S_ERR;
                    else if (w_len == '0) w_next = S_CSUM;
                    else                  w_next = S_DATA_L;
                end
            end
            S_DATA_L: if (rx_valid) w_next = S_DATA_H;
            S_DATA_H: if (rx_valid) w_next = w_last ? S_CSUM : S_DATA_L;
            S_CSUM:   if (rx_valid) w_next = w_csum_ok ? S_DONE : S_ERR;
        endcase
        if (w_expire) w_next = S_ERR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_lo    <= '0;
            r_csum  <= '0;
            r_tmo   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 2'd0;
            r_words <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            r_tmo   <= (w_in_frame && !rx_valid && !w_expire) ?
                       r_tmo + TW'(1) : '0;
            if (w_expire) r_err <= 2'd3;
            if (rx_valid) begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (w_sync) begin
                            r_hold  <= 1'b1;
                            r_done  <= 1'b0;
                            r_err   <= 2'd0;
                            r_words <= '0;
                            r_csum  <= '0;
                        end
                    end
                    S_LEN_L: r_len[7:0] <= rx_byte;
                    S_LEN_H: begin
                        r_len[15:8] <= rx_byte;
                        if (w_ovf) r_err <= 2'd2;
                    end
                    S_DATA_L: begin
                        r_lo   <= rx_byte;
                        r_csum <= w_csum_add;
                    end
                    S_DATA_H: begin
                        r_csum  <= w_csum_add;
                        r_data  <= DATA_WIDTH'({rx_byte, r_lo});
                        r_addr  <= r_words[ADDR_WIDTH-1:0];
                        r_we    <= 1'b1;
                        r_words <= r_words + WW'(1);
                    end
                    S_CSUM: begin
                        if (w_csum_ok) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_err  <= 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_addr    = r_addr;
    assign imem_data    = r_data;
    assign imem_we      = r_we;
    assign cpu_hold     = r_hold;
    assign boot_done    = r_done;
    assign boot_err     = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed bench for uart_boot_ctrl: frames, checksum/length/timeout errors,
// stray bytes and asynchronous reset, with a short timeout window.
module tb_uart_boot_ctrl;

    logic       clk;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] imem_addr;
    logic [15:0] imem_data;
    logic       imem_we;
    logic       cpu_hold;
    logic       boot_done;
    logic [1:0] boot_err;
    logic [8:0] words_loaded;

    int total = 0;
    int bad   = 0;
    int wcnt  = 0;
    int base;
    logic [7:0]  wa [64];
    logic [15:0] wd [64];

    uart_boot_ctrl #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .imem_we(imem_we),
        .cpu_hold(cpu_hold),
        .boot_done(boot_done),
        .boot_err(boot_err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wcnt < 64) begin
                wa[wcnt] = imem_addr;
                wd[wcnt] = imem_data;
            end
            wcnt = wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic good_frame();
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        send(8'h44); send(8'h55); send(8'h66);
        send(8'h65);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", boot_done, 0);
        chk("rst_err", boot_err, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_data", imem_data, 0);
        reset = 1'b1;
        @(negedge clk);

        send(8'h00); send(8'hFF); send(8'h12);
        @(negedge clk);
        chk("stray_done", boot_done, 0);
        chk("stray_err", boot_err, 0);
        chk("stray_hold", cpu_hold, 1);
        chk("stray_writes", wcnt, 0);

        base = wcnt;
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h11); send(8'h22);
        chk("lat_we", imem_we, 1);
        chk("lat_addr", imem_addr, 0);
        chk("lat_data", imem_data, 16'h2211);
        chk("lat_words", words_loaded, 1);
        send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        chk("pre_csum_hold", cpu_hold, 1);
        send(8'h65);
        @(negedge clk);
        chk("good_writes", wcnt - base, 3);
        chk("good_a0", wa[base], 0);
        chk("good_d0", wd[base], 16'h2211);
        chk("good_a1", wa[base+1], 1);
        chk("good_d1", wd[base+1], 16'h4433);
        chk("good_a2", wa[base+2], 2);
        chk("good_d2", wd[base+2], 16'h6655);
        chk("good_done", boot_done, 1);
        chk("good_hold", cpu_hold, 0);
        chk("good_words", words_loaded, 3);
        chk("good_err", boot_err, 0);

        base = wcnt;
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        send(8'h44); send(8'h55); send(8'h66);
        send(8'h64);
        @(negedge clk);
        chk("bcs_writes", wcnt - base, 3);
        chk("bcs_err", boot_err, 1);
        chk("bcs_done", boot_done, 0);
        chk("bcs_hold", cpu_hold, 1);
        good_frame();
        chk("recov_done", boot_done, 1);
        chk("recov_hold", cpu_hold, 0);
        chk("recov_err", boot_err, 0);

        base = wcnt;
        send(8'hA5); send(8'h01); send(8'h01);
        chk("ovf_err", boot_err, 2);
        chk("ovf_hold", cpu_hold, 1);
        repeat (3) @(negedge clk);
        chk("ovf_writes", wcnt - base, 0);

        send(8'hA5); send(8'h00); send(8'h01);
        chk("len256_err", boot_err, 0);
        repeat (14) @(negedge clk);
        chk("len256_tmo_early", boot_err, 0);
        @(negedge clk);
        chk("len256_tmo", boot_err, 3);

        base = wcnt;
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        chk("zero_done", boot_done, 1);
        chk("zero_hold", cpu_hold, 0);
        chk("zero_words", words_loaded, 0);
        chk("zero_writes", wcnt - base, 0);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
        chk("zero_bad_err", boot_err, 1);
        chk("zero_bad_done", boot_done, 0);

        send(8'hA5); send(8'h03); send(8'h00); send(8'h11);
        repeat (14) @(negedge clk);
        chk("tmo_early", boot_err, 0);
        @(negedge clk);
        chk("tmo_err", boot_err, 3);
        chk("tmo_hold", cpu_hold, 1);
        repeat (20) @(negedge clk);
        chk("tmo_idle_err", boot_err, 3);

        send(8'hA5); send(8'h03); send(8'h00); send(8'h11);
        repeat (14) @(negedge clk);
        send(8'h22);
        chk("edge_err", boot_err, 0);
        send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        send(8'h65);
        chk("edge_done", boot_done, 1);
        chk("edge_err2", boot_err, 0);

        base = wcnt;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hA5); send(8'hA5); send(8'h4A);
        @(negedge clk);
        chk("syncdata_done", boot_done, 1);
        chk("syncdata_writes", wcnt - base, 1);
        chk("syncdata_d0", wd[base], 16'hA5A5);

        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        chk("mid_words", words_loaded, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_hold", cpu_hold, 1);
        chk("arst_words", words_loaded, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_data", imem_data, 0);
        chk("arst_done", boot_done, 0);
        chk("arst_err", boot_err, 0);
        chk("arst_we", imem_we, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        good_frame();
        chk("post_rst_done", boot_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
